// File: rtl/lc3b_mem_pkg.sv
// rtl/lc3b_mem_pkg.sv - shared FSM state, owner encoding and latency default for mem_arbiter
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, write-byte replication and read sign-extension
module mem_lane_align (
    input  logic        byte_i,
    input  logic        addr0_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    output logic [1:0]  be_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o
);

    logic [7:0] rd_lane;

    // Steer lanes: word accesses use both lanes, byte accesses pick the lane from addr[0]
    always_comb begin
        rd_lane = addr0_i ? rdata_i[15:8] : rdata_i[7:0];
        if (byte_i) begin
            be_o    = addr0_i ? 2'b10 : 2'b01;
            wdata_o = {wdata_i[7:0], wdata_i[7:0]};
            rdata_o = {{8{rd_lane[7]}}, rd_lane};
        end else begin
            be_o    = 2'b11;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug memory arbiter; MEM_ARBITER_RR_EN selects round-robin over fixed dbg priority
module mem_arbiter
    import lc3b_mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic        dbg_byte,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  owner
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    arb_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  own_q;
    logic        we_q;
    logic        byte_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] dbg_rdata_q;

    logic        start;
    logic        finish;
    logic        grant_dbg;
    logic [1:0]  lane_be;
    logic [15:0] lane_wdata;
    logic [15:0] lane_rdata;
    logic [15:0] rd_result;

`ifdef MEM_ARBITER_RR_EN
    logic        last_dbg_q;

    // On a tie the requester not served last wins
    always_comb begin
        grant_dbg = dbg_req && (!cpu_req || !last_dbg_q);
    end

    // Remember who was served, updated once per completed transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dbg_q <= 1'b1;
        end else if (state_q == ST_DONE) begin
            last_dbg_q <= (own_q == OWN_DBG);
        end
    end
`else
    // Fixed priority: the debug port always wins a tie
    always_comb begin
        grant_dbg = dbg_req;
    end
`endif

    mem_lane_align u_lane (
        .byte_i  (byte_q),
        .addr0_i (addr_q[0]),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    // FSM state and access-cycle counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and memory-side outputs; memory outputs are quiet outside ACCESS
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        finish    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = 15'd0;
        mem_wdata = 16'd0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 3'd0;
                    start   = 1'b1;
                end
            end
            ST_ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_be    = lane_be;
                mem_addr  = addr_q[15:1];
                mem_wdata = lane_wdata;
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes report zero; reads report the lane-aligned memory word
    always_comb begin
        rd_result = we_q ? 16'd0 : lane_rdata;
    end

    // Latch the winner's request at grant and capture read data on the last access cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q       <= OWN_NONE;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dbg_rdata_q <= 16'd0;
        end else begin
            if (start) begin
                if (grant_dbg) begin
                    own_q   <= OWN_DBG;
                    we_q    <= dbg_we;
                    byte_q  <= dbg_byte;
                    addr_q  <= dbg_addr;
                    wdata_q <= dbg_wdata;
                end else begin
                    own_q   <= OWN_CPU;
                    we_q    <= cpu_we;
                    byte_q  <= cpu_byte;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end
            end
            if (finish) begin
                if (own_q == OWN_DBG) begin
                    dbg_rdata_q <= rd_result;
                end else begin
                    cpu_rdata_q <= rd_result;
                end
            end
        end
    end

    // Requester-side outputs: ack only in DONE, owner hidden while idle
    always_comb begin
        cpu_ack   = (state_q == ST_DONE) && (own_q == OWN_CPU);
        dbg_ack   = (state_q == ST_DONE) && (own_q == OWN_DBG);
        owner     = (state_q == ST_IDLE) ? OWN_NONE : own_q;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access cycles per transaction (legal 1..7).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-005 cpu_we / cpu_byte  input  1 each  write (1) or read (0); byte (1) or word (0) access.
REQ-006 cpu_addr  input  16  byte address.
REQ-007 cpu_wdata  input  16  write data; byte writes use bits [7:0].
REQ-008 cpu_rdata  output  16  read data, valid while cpu_ack=1.
REQ-009 cpu_ack  output  1  one-cycle completion pulse.
REQ-010 dbg_req, dbg_we, dbg_byte, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same widths and meanings as the cpu_* ports, for the program loader/debug port.
REQ-011 mem_en  output  1  memory enable.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_be  output  2  byte-lane enables, [1]=high byte.
REQ-014 mem_addr  output  15  word address (byte address bits [15:1]).
REQ-015 mem_wdata  output  16  memory write data.
REQ-016 mem_rdata  input  16  memory read data, valid on the last access cycle.
REQ-017 owner  output  2  00 none, 01 cpu, 10 dbg; current grant.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any req=1; ACCESS stays MEM_LAT cycles, then ->DONE; DONE->IDLE after one cycle.
REQ-019 On the IDLE->ACCESS edge, the winner's we/byte/addr/wdata are latched; later changes to requester inputs are ignored until DONE.
REQ-020 In ACCESS: mem_en=1; mem_we=latched we; mem_addr, mem_be and mem_wdata are driven from latched values; all mem_* outputs are 0 outside ACCESS.
REQ-021 Word access: mem_be=11; addr[0] is ignored.
REQ-022 Byte access: mem_be=01 if addr[0]=0, 10 if addr[0]=1; mem_wdata={wdata[7:0],wdata[7:0]}.
REQ-023 Reads: mem_rdata is captured on the last ACCESS cycle; a word read returns it unchanged; a byte read returns the addressed lane sign-extended to 16 bits.
REQ-024 In DONE, the owner's ack=1 for exactly one cycle with rdata valid; writes return rdata=0.
REQ-025 The other requester's ack stays 0; its rdata holds its last value.
REQ-026 Latency: ack rises MEM_LAT+1 cycles after the cycle req was sampled in IDLE.
REQ-027 A req still high in the cycle after DONE (IDLE) starts a new transaction; requesters deassert req on the ack cycle.
REQ-028 A requester that drops req mid-ACCESS does not abort the transaction; ack is still issued.
REQ-029 Simultaneous cpu_req and dbg_req in IDLE are resolved per REQ-033/034; the loser waits with no ack.
REQ-030 owner reflects the granted requester in ACCESS and DONE, and 00 in IDLE.

Reset
REQ-031 reset at any cycle, including mid-ACCESS, forces IDLE next edge; the transaction is dropped with no ack and no further mem_we.
REQ-032 Reset values: all mem_* outputs 0, both ack 0, both rdata 0x0000, owner 00, last-served register = dbg.

Configuration
REQ-033 With MEM_ARBITER_RR_EN defined, arbitration is round-robin: on a tie, the requester not served last wins; the last-served register updates at each DONE.
REQ-034 Without MEM_ARBITER_RR_EN, arbitration is fixed priority dbg > cpu, and the last-served register is absent.

Structure
REQ-035 Shared package lc3b_mem_pkg holds the FSM state enum, owner encoding constants, and MEM_LAT default.
REQ-036 Byte-lane steering (mem_be, write replication, read sign-extension) is one sub-module, mem_lane_align.

Verification
REQ-037 MEM_LAT=2, CPU word read addr 0x3001, mem_rdata=0xBEEF -> mem_addr=0x1800, be=11, cpu_ack 3 cycles after req, cpu_rdata=0xBEEF.
REQ-038 CPU byte read addr 0x3001, mem_rdata=0x80FF -> be=10, cpu_rdata=0xFF80.
REQ-039 dbg byte write addr 0x0004, wdata=0x12A5 -> mem_we=1, be=01, mem_wdata=0xA5A5, dbg_ack pulse.
REQ-040 Both requests held continuously -> without MEM_ARBITER_RR_EN: dbg, dbg, dbg...; with it: cpu, dbg, cpu, dbg (first winner cpu after reset).
REQ-041 reset asserted in the 2nd ACCESS cycle of a write -> next cycle mem_en=0, mem_we=0, owner=00, no ack ever issued.
REQ-042 cpu_req dropped after one ACCESS cycle -> transaction completes and cpu_ack still pulses once.
